// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if
//   Groups the requester-side handshake and the UART sender link of the
//   transmit arbiter into one bundle.
//   Signals:
//     req[1:0]     per-requester byte request level (bit 0 = CPU, bit 1 = debug)
//     data0/data1  byte offered by requester 0 / 1
//     ack[1:0]     one-cycle pulse: byte of that requester accepted
//     done[1:0]    one-cycle pulse: owner's byte completed on the line
//     err[1:0]     one-cycle pulse: owner's byte aborted by timeout
//     tx_data      byte presented to the UART sender
//     tx_trigger   launch strobe to the sender (acts on its rising edge)
//     tx_finish    sender completion pulse
//     busy         arbiter is not idle
//   Modports: slave = arbiter side, master = requesters + sender side.
interface uart_tx_arbiter_if;
    logic [1:0] req;
    logic [7:0] data0;
    logic [7:0] data1;
    logic [1:0] ack;
    logic [1:0] done;
    logic [1:0] err;
    logic [7:0] tx_data;
    logic       tx_trigger;
    logic       tx_finish;
    logic       busy;

    modport slave (
        input  req, data0, data1, tx_finish,
        output ack, done, err, tx_data, tx_trigger, busy
    );

    modport master (
        output req, data0, data1, tx_finish,
        input  ack, done, err, tx_data, tx_trigger, busy
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one UART sender between two byte requesters. A granted byte is
//   latched, launched with a TRIG_LEN-cycle trigger strobe, and the owner is
//   told whether it completed (done) or was abandoned after TIMEOUT cycles
//   without a completion pulse (err). Ties alternate between requesters.
//   Ports:
//     sysclk  sole clock, rising edge
//     reset   asynchronous, active-high
//     bus     uart_tx_arbiter_if.slave (req/data0/data1/tx_finish in,
//             ack/done/err/tx_data/tx_trigger/busy out)
//   Parameters:
//     TRIG_LEN  cycles tx_trigger is held high per byte (2..15)
//     TIMEOUT   cycles to wait for tx_finish before aborting
module uart_tx_arbiter #(
    parameter int unsigned TRIG_LEN = 2,
    parameter logic [15:0] TIMEOUT  = 16'd65535
) (
    input  logic              sysclk,
    input  logic              reset,
    uart_tx_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_DONE = 2'd2,
        COOLDOWN  = 2'd3
    } state_t;

    localparam logic [3:0] TRIG_LAST = 4'(TRIG_LEN - 1);

    state_t      state, state_nxt;
    logic [3:0]  trig_cnt, trig_cnt_nxt;
    logic [15:0] wait_cnt, wait_cnt_nxt;
    logic [15:0] wait_cnt_inc;
    logic        last_grant, last_grant_nxt;
    logic        owner, owner_nxt;
    logic        grant_idx;
    logic [7:0]  tx_data_q, tx_data_nxt;
    logic        tx_trigger_q, tx_trigger_nxt;
    logic [1:0]  ack_q, ack_nxt;
    logic [1:0]  done_q, done_nxt;
    logic [1:0]  err_q, err_nxt;

    assign wait_cnt_inc = wait_cnt + 16'd1;

    // Single request wins outright; on a tie the requester not served last
    // wins. req == 0 never reaches a grant, so its value here is don't-care.
    always_comb begin
        case (bus.req)
            2'b01:   grant_idx = 1'b0;
            2'b10:   grant_idx = 1'b1;
            default: grant_idx = ~last_grant;
        endcase
    end

    always_comb begin
        state_nxt      = state;
        trig_cnt_nxt   = trig_cnt;
        wait_cnt_nxt   = wait_cnt;
        last_grant_nxt = last_grant;
        owner_nxt      = owner;
        tx_data_nxt    = tx_data_q;
        ack_nxt        = 2'b00;
        done_nxt       = 2'b00;
        err_nxt        = 2'b00;

        case (state)
            IDLE: begin
                if (bus.req != 2'b00) begin
                    state_nxt      = LAUNCH;
                    ack_nxt        = grant_idx ? 2'b10 : 2'b01;
                    owner_nxt      = grant_idx;
                    last_grant_nxt = grant_idx;
                    tx_data_nxt    = grant_idx ? bus.data1 : bus.data0;
                    trig_cnt_nxt   = 4'd0;
                end
            end
            LAUNCH: begin
                // tx_finish here belongs to an earlier byte and is ignored.
                if (trig_cnt == TRIG_LAST) begin
                    state_nxt    = WAIT_DONE;
                    wait_cnt_nxt = 16'd0;
                end else begin
                    trig_cnt_nxt = trig_cnt + 4'd1;
                end
            end
            WAIT_DONE: begin
                // Completion outranks a timeout landing on the same edge.
                if (bus.tx_finish) begin
                    done_nxt  = owner ? 2'b10 : 2'b01;
                    state_nxt = COOLDOWN;
                end else if (wait_cnt_inc == TIMEOUT) begin
                    err_nxt   = owner ? 2'b10 : 2'b01;
                    state_nxt = COOLDOWN;
                end else begin
                    wait_cnt_nxt = wait_cnt_inc;
                end
            end
            COOLDOWN: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Registered strobe follows the LAUNCH state exactly, glitch-free.
        tx_trigger_nxt = (state_nxt == LAUNCH);
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            trig_cnt     <= 4'd0;
            wait_cnt     <= 16'd0;
            last_grant   <= 1'b1;
            owner        <= 1'b0;
            tx_data_q    <= 8'h00;
            tx_trigger_q <= 1'b0;
            ack_q        <= 2'b00;
            done_q       <= 2'b00;
            err_q        <= 2'b00;
        end else begin
            state        <= state_nxt;
            trig_cnt     <= trig_cnt_nxt;
            wait_cnt     <= wait_cnt_nxt;
            last_grant   <= last_grant_nxt;
            owner        <= owner_nxt;
            tx_data_q    <= tx_data_nxt;
            tx_trigger_q <= tx_trigger_nxt;
            ack_q        <= ack_nxt;
            done_q       <= done_nxt;
            err_q        <= err_nxt;
        end
    end

    assign bus.ack        = ack_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
    assign bus.tx_data    = tx_data_q;
    assign bus.tx_trigger = tx_trigger_q;
    assign bus.busy       = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
//   Directed bench for uart_tx_arbiter (TRIG_LEN=2, TIMEOUT=20): a per-cycle
//   vector table for tie fairness, a single request with a stale finish, and
//   data stability, followed by hand-written timeout, finish-on-timeout and
//   reset-in-LAUNCH sequences.
module tb_uart_tx_arbiter;

    logic sysclk;
    logic reset;
    int   total;
    int   bad;

    uart_tx_arbiter_if bus ();

    uart_tx_arbiter #(
        .TRIG_LEN (2),
        .TIMEOUT  (16'd20)
    ) dut (
        .sysclk (sysclk),
        .reset  (reset),
        .bus    (bus)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    typedef struct {
        logic [1:0] req;
        logic [7:0] d0;
        logic [7:0] d1;
        logic       fin;
        logic [1:0] ack;
        logic [1:0] done;
        logic [1:0] err;
        logic [7:0] txd;
        logic       trig;
        logic       busy;
    } vec_t;

    vec_t tbl[$];

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [1:0] rq, input logic [7:0] a, input logic [7:0] b,
                       input logic f, input logic [1:0] ak, input logic [1:0] dn,
                       input logic [1:0] er, input logic [7:0] td, input logic tg,
                       input logic by);
        vec_t v;
        v.req = rq; v.d0 = a; v.d1 = b; v.fin = f;
        v.ack = ak; v.done = dn; v.err = er; v.txd = td; v.trig = tg; v.busy = by;
        tbl.push_back(v);
    endtask

    initial begin
        logic [1:0] o;
        logic [7:0] dd;
        total = 0;
        bad   = 0;

        // Tie fairness: req=11 held for four bytes, grant order 0,1,0,1.
        for (int n = 0; n < 4; n++) begin
            o  = (n % 2 == 0) ? 2'b01 : 2'b10;
            dd = (n % 2 == 0) ? 8'h11 : 8'h22;
            add(2'b11, 8'h11, 8'h22, 1'b0, o,     2'b00, 2'b00, dd, 1'b1, 1'b1);
            add(2'b11, 8'h11, 8'h22, 1'b0, 2'b00, 2'b00, 2'b00, dd, 1'b1, 1'b1);
            add(2'b11, 8'h11, 8'h22, 1'b0, 2'b00, 2'b00, 2'b00, dd, 1'b0, 1'b1);
            add(2'b11, 8'h11, 8'h22, 1'b1, 2'b00, o,     2'b00, dd, 1'b0, 1'b1);
            add(2'b11, 8'h11, 8'h22, 1'b0, 2'b00, 2'b00, 2'b00, dd, 1'b0, 1'b0);
        end
        // Single request A5, with a stale tx_finish on the last LAUNCH edge.
        add(2'b01, 8'hA5, 8'h00, 1'b0, 2'b01, 2'b00, 2'b00, 8'hA5, 1'b1, 1'b1);
        add(2'b00, 8'hA5, 8'h00, 1'b0, 2'b00, 2'b00, 2'b00, 8'hA5, 1'b1, 1'b1);
        add(2'b00, 8'hA5, 8'h00, 1'b1, 2'b00, 2'b00, 2'b00, 8'hA5, 1'b0, 1'b1);
        add(2'b00, 8'hA5, 8'h00, 1'b0, 2'b00, 2'b00, 2'b00, 8'hA5, 1'b0, 1'b1);
        add(2'b00, 8'hA5, 8'h00, 1'b1, 2'b00, 2'b01, 2'b00, 8'hA5, 1'b0, 1'b1);
        add(2'b00, 8'hA5, 8'h00, 1'b0, 2'b00, 2'b00, 2'b00, 8'hA5, 1'b0, 1'b0);
        // Data stability: data0 moves 3C -> FF after ack, tx_data holds 3C.
        add(2'b01, 8'h3C, 8'h00, 1'b0, 2'b01, 2'b00, 2'b00, 8'h3C, 1'b1, 1'b1);
        add(2'b00, 8'hFF, 8'h00, 1'b0, 2'b00, 2'b00, 2'b00, 8'h3C, 1'b1, 1'b1);
        add(2'b00, 8'hFF, 8'h00, 1'b0, 2'b00, 2'b00, 2'b00, 8'h3C, 1'b0, 1'b1);
        add(2'b00, 8'hFF, 8'h00, 1'b1, 2'b00, 2'b01, 2'b00, 8'h3C, 1'b0, 1'b1);
        add(2'b00, 8'hFF, 8'h00, 1'b0, 2'b00, 2'b00, 2'b00, 8'h3C, 1'b0, 1'b0);

        // Reset state
        reset         = 1'b1;
        bus.req       = 2'b00;
        bus.data0     = 8'h00;
        bus.data1     = 8'h00;
        bus.tx_finish = 1'b0;
        tick();
        tick();
        check("rst ack",  {6'd0, bus.ack},        8'h00);
        check("rst done", {6'd0, bus.done},       8'h00);
        check("rst err",  {6'd0, bus.err},        8'h00);
        check("rst txd",  bus.tx_data,            8'h00);
        check("rst trig", {7'd0, bus.tx_trigger}, 8'h00);
        check("rst busy", {7'd0, bus.busy},       8'h00);
        reset = 1'b0;

        // Vector table
        for (int i = 0; i < tbl.size(); i++) begin
            bus.req       = tbl[i].req;
            bus.data0     = tbl[i].d0;
            bus.data1     = tbl[i].d1;
            bus.tx_finish = tbl[i].fin;
            tick();
            check($sformatf("row%0d ack", i),  {6'd0, bus.ack},        {6'd0, tbl[i].ack});
            check($sformatf("row%0d done", i), {6'd0, bus.done},       {6'd0, tbl[i].done});
            check($sformatf("row%0d err", i),  {6'd0, bus.err},        {6'd0, tbl[i].err});
            check($sformatf("row%0d txd", i),  bus.tx_data,            tbl[i].txd);
            check($sformatf("row%0d trig", i), {7'd0, bus.tx_trigger}, {7'd0, tbl[i].trig});
            check($sformatf("row%0d busy", i), {7'd0, bus.busy},       {7'd0, tbl[i].busy});
        end

        // Timeout: grant requester 1, never finish, err=10 twenty cycles
        // after WAIT_DONE entry.
        bus.req       = 2'b10;
        bus.data1     = 8'h5A;
        bus.tx_finish = 1'b0;
        tick();
        check("to ack", {6'd0, bus.ack}, 8'h02);
        check("to txd", bus.tx_data,     8'h5A);
        bus.req = 2'b00;
        tick();
        tick();
        check("to wait trig", {7'd0, bus.tx_trigger}, 8'h00);
        for (int k = 1; k < 20; k++) begin
            tick();
            check($sformatf("to early err%0d", k), {6'd0, bus.err},  8'h00);
            check($sformatf("to early dn%0d", k),  {6'd0, bus.done}, 8'h00);
        end
        tick();
        check("to err",  {6'd0, bus.err},  8'h02);
        check("to done", {6'd0, bus.done}, 8'h00);
        check("to cool busy", {7'd0, bus.busy}, 8'h01);
        tick();
        check("to idle busy", {7'd0, bus.busy}, 8'h00);
        check("to idle err",  {6'd0, bus.err},  8'h00);

        // Next request served, then tx_finish lands on the timeout edge.
        bus.req   = 2'b01;
        bus.data0 = 8'hC3;
        tick();
        check("sim ack", {6'd0, bus.ack}, 8'h01);
        check("sim txd", bus.tx_data,     8'hC3);
        bus.req = 2'b00;
        tick();
        tick();
        for (int k = 1; k < 20; k++) begin
            tick();
        end
        bus.tx_finish = 1'b1;
        tick();
        bus.tx_finish = 1'b0;
        check("sim done", {6'd0, bus.done}, 8'h01);
        check("sim err",  {6'd0, bus.err},  8'h00);
        tick();
        check("sim idle busy", {7'd0, bus.busy}, 8'h00);
        check("sim idle err",  {6'd0, bus.err},  8'h00);

        // Reset while tx_trigger is high, req=01 stays pending.
        bus.req   = 2'b01;
        bus.data0 = 8'h77;
        tick();
        check("rl trig", {7'd0, bus.tx_trigger}, 8'h01);
        check("rl txd",  bus.tx_data,            8'h77);
        #2;
        reset = 1'b1;
        #1;
        check("rl async trig", {7'd0, bus.tx_trigger}, 8'h00);
        check("rl async busy", {7'd0, bus.busy},       8'h00);
        check("rl async txd",  bus.tx_data,            8'h00);
        check("rl async ack",  {6'd0, bus.ack},        8'h00);
        tick();
        check("rl hold done", {6'd0, bus.done}, 8'h00);
        check("rl hold err",  {6'd0, bus.err},  8'h00);
        reset = 1'b0;
        tick();
        check("rl re ack",  {6'd0, bus.ack},        8'h01);
        check("rl re txd",  bus.tx_data,            8'h77);
        check("rl re trig", {7'd0, bus.tx_trigger}, 8'h01);
        bus.req = 2'b00;
        tick();
        tick();
        bus.tx_finish = 1'b1;
        tick();
        bus.tx_finish = 1'b0;
        check("rl done", {6'd0, bus.done}, 8'h01);
        tick();
        check("rl idle busy", {7'd0, bus.busy}, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL provide parameter TRIG_LEN, default 2, the number of sysclk cycles tx_trigger is held high per byte (legal range 2..15).
REQ-002 The block SHALL provide parameter TIMEOUT, default 16'd65535, the number of sysclk cycles to wait for tx_finish before aborting.
REQ-003 Port sysclk, input, 1, sole clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1, asynchronous, active-high reset.
REQ-005 Port req, input, 2, per-requester byte request (bit 0 = CPU, bit 1 = debug); level, held until ack.
REQ-006 Port data0 / data1, input, 8 each, byte offered by requester 0 / 1.
REQ-007 Port ack, output, 2, one-cycle pulse to the requester whose byte was accepted.
REQ-008 Port done, output, 2, one-cycle pulse to the owner when its byte has completed on the line.
REQ-009 Port err, output, 2, one-cycle pulse to the owner when its byte is aborted by timeout.
REQ-010 Port tx_data, output, 8, byte presented to the UART sender.
REQ-011 Port tx_trigger, output, 1, launch strobe to the sender (sender acts on its rising edge).
REQ-012 Port tx_finish, input, 1, sender completion pulse.
REQ-013 Port busy, output, 1, high whenever state is not IDLE.

Function
REQ-014 The FSM SHALL have states IDLE, LAUNCH, WAIT_DONE, COOLDOWN.
REQ-015 In IDLE with req != 0, the block SHALL grant, latch the granted byte into tx_data, pulse ack for the granted bit in that same cycle, and move to LAUNCH.
REQ-016 Arbitration: single request wins; if req == 2'b11, the requester not granted last SHALL win; the last-grant pointer resets to 1 so requester 0 wins the first tie.
REQ-017 In LAUNCH, tx_trigger SHALL be high for exactly TRIG_LEN cycles, then the state SHALL become WAIT_DONE with tx_trigger low.
REQ-018 tx_data SHALL remain stable from grant until the state returns to IDLE; changes on data0/data1 after ack SHALL be ignored.
REQ-019 In WAIT_DONE, on tx_finish == 1, the block SHALL pulse done for the owner and move to COOLDOWN.
REQ-020 A tx_finish arriving during LAUNCH SHALL be ignored (stale completion).
REQ-021 A 16-bit timeout counter SHALL clear on entry to WAIT_DONE and increment each WAIT_DONE cycle; on reaching TIMEOUT without tx_finish, the block SHALL pulse err for the owner (no done) and move to COOLDOWN.
REQ-022 If tx_finish and the timeout occur in the same cycle, tx_finish SHALL take priority (done, not err).
REQ-023 COOLDOWN SHALL last 1 cycle, so tx_trigger is low for at least 2 cycles between bytes, then return to IDLE.
REQ-024 Requests arriving while busy SHALL wait; no ack is issued outside IDLE.
REQ-025 At most one bit of ack, done and err SHALL be high in any cycle, and only one of ack/done/err SHALL be active per cycle.
REQ-026 Minimum per-byte overhead SHALL be 1 (IDLE) + TRIG_LEN + 1 (finish) + 1 (COOLDOWN) cycles plus sender time.

Reset
REQ-027 On reset assertion, regardless of state, the block SHALL immediately enter IDLE with tx_trigger=0, tx_data=8'h00, ack=done=err=2'b00, busy=0, timeout counter=0, last-grant pointer=1.
REQ-028 A reset mid-byte SHALL drop the byte silently (no done/err); the first edge after release SHALL evaluate req normally.

Verification
REQ-029 Single request: req=01, data0=8'hA5 -> ack=01 in one cycle, tx_data=A5, tx_trigger high 2 cycles; tx_finish pulse -> done=01, busy low 2 cycles later.
REQ-030 Tie fairness: req=11 held for 4 bytes, data0=11, data1=22 -> grant order 0,1,0,1 with tx_data 11,22,11,22.
REQ-031 Timeout: TIMEOUT=20, grant req1, never assert tx_finish -> err=10 exactly 20 cycles after WAIT_DONE entry, no done; next request is served.
REQ-032 Simultaneous events: assert tx_finish on the timeout cycle -> done pulses, err stays 00.
REQ-033 Reset in LAUNCH: assert reset while tx_trigger=1 -> tx_trigger, busy, tx_data drop to 0 asynchronously; no done/err; a pending req=01 is acked on the first edge after release.
REQ-034 Data stability: change data0 from 8'h3C to 8'hFF one cycle after ack -> tx_data stays 3C until IDLE.
